// File: rtl/core2axi4l_mo_pkg.sv
// Shared types and constants for the Ibex-to-AXI4-Lite multi-outstanding bridge.
package core2axi4l_mo_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam logic [2:0] PROT_INSTR = 3'b100;
  localparam logic [2:0] PROT_DATA  = 3'b000;

  // EXOKAY is treated as a successful access; only slave and decode errors flag err.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == SLVERR) || (resp == DECERR);
  endfunction

endpackage

// File: rtl/core2axi4l_order_fifo.sv
// Small circular FIFO; pointers wrap at Depth so non-power-of-two depths work.
module core2axi4l_order_fifo #(
  parameter int Depth = 2,
  parameter int Width = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int CntW = $clog2(Depth + 1);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Next-state for pointers and occupancy; simultaneous push and pop keep the count.
  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // State and storage registers; storage is cleared too so head reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/core2axi4l_mo.sv
// Ibex req/gnt/rvalid to AXI4-Lite master with in-order multi-outstanding responses.
module core2axi4l_mo
  import core2axi4l_mo_pkg::*;
#(
  parameter int         MaxOutstanding = 2,
  parameter bit         RspReg         = 1'b0,
  parameter logic [2:0] Prot           = 3'b000,
  parameter int         ADDR_W         = 32,
  parameter int         DATA_W         = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  // Ibex side
  input  logic                core_req_i,
  input  logic                core_we_i,
  input  logic [DATA_W/8-1:0] core_be_i,
  input  logic [ADDR_W-1:0]   core_addr_i,
  input  logic [DATA_W-1:0]   core_wdata_i,
  output logic                core_gnt_o,
  output logic                core_rvalid_o,
  output logic [DATA_W-1:0]   core_rdata_o,
  output logic                core_err_o,
  // AXI4-Lite master
  output logic                axi_awvalid_o,
  input  logic                axi_awready_i,
  output logic [ADDR_W-1:0]   axi_awaddr_o,
  output logic [2:0]          axi_awprot_o,
  output logic                axi_wvalid_o,
  input  logic                axi_wready_i,
  output logic [DATA_W-1:0]   axi_wdata_o,
  output logic [DATA_W/8-1:0] axi_wstrb_o,
  input  logic                axi_bvalid_i,
  output logic                axi_bready_o,
  input  logic [1:0]          axi_bresp_i,
  output logic                axi_arvalid_o,
  input  logic                axi_arready_i,
  output logic [ADDR_W-1:0]   axi_araddr_o,
  output logic [2:0]          axi_arprot_o,
  input  logic                axi_rvalid_i,
  output logic                axi_rready_o,
  input  logic [DATA_W-1:0]   axi_rdata_i,
  input  logic [1:0]          axi_rresp_i
);

  localparam int CntW = $clog2(MaxOutstanding + 1);

  logic            ord_full, ord_empty, ord_head;
  logic [CntW-1:0] ord_count;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic            issue_ok, ar_hs, aw_hs, w_hs, gnt_wr;
  logic            r_acc, b_acc, rsp_pop, rsp_err;
  logic [DATA_W-1:0] rsp_data;
  logic            unused_ord;

  // Issue side: a full order FIFO blocks issue even if a response pops this cycle.
  assign issue_ok      = core_req_i & ~ord_full;
  assign axi_arvalid_o = issue_ok & ~core_we_i;
  assign axi_awvalid_o = issue_ok & core_we_i & ~aw_done_q;
  assign axi_wvalid_o  = issue_ok & core_we_i & ~w_done_q;
  assign axi_araddr_o  = core_addr_i;
  assign axi_awaddr_o  = core_addr_i;
  assign axi_wdata_o   = core_wdata_i;
  assign axi_wstrb_o   = core_be_i;
  assign axi_arprot_o  = Prot;
  assign axi_awprot_o  = Prot;

  assign ar_hs      = axi_arvalid_o & axi_arready_i;
  assign aw_hs      = axi_awvalid_o & axi_awready_i;
  assign w_hs       = axi_wvalid_o & axi_wready_i;
  assign gnt_wr     = issue_ok & core_we_i & (aw_done_q | aw_hs) & (w_done_q | w_hs);
  assign core_gnt_o = ar_hs | gnt_wr;

  // Remember which half of a write already handshook until the whole write is granted.
  always_comb begin
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    if (gnt_wr) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else begin
      if (aw_hs) aw_done_d = 1'b1;
      if (w_hs)  w_done_d  = 1'b1;
    end
  end

  // Partial-write flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  core2axi4l_order_fifo #(
    .Depth (MaxOutstanding),
    .Width (1)
  ) u_order (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (core_gnt_o),
    .wdata_i (core_we_i),
    .pop_i   (rsp_pop),
    .head_o  (ord_head),
    .full_o  (ord_full),
    .empty_o (ord_empty),
    .count_o (ord_count)
  );

  assign unused_ord = ^ord_count;

  // Only the channel matching the oldest outstanding operation is allowed to complete.
  assign axi_rready_o = ~ord_empty & (ord_head == OP_READ);
  assign axi_bready_o = ~ord_empty & (ord_head == OP_WRITE);
  assign r_acc        = axi_rvalid_i & axi_rready_o;
  assign b_acc        = axi_bvalid_i & axi_bready_o;
  assign rsp_pop      = r_acc | b_acc;
  assign rsp_data     = r_acc ? axi_rdata_i : '0;
  assign rsp_err      = r_acc ? resp_is_err(axi_rresp_i) :
                        b_acc ? resp_is_err(axi_bresp_i) : 1'b0;

  if (RspReg) begin : g_rsp_reg
    logic              rsp_empty, rsp_full;
    logic [DATA_W:0]   rsp_head;
    logic [0:0]        rsp_count;
    logic              unused_rsp;

    // One-entry FIFO drained every cycle acts as the response register.
    core2axi4l_order_fifo #(
      .Depth (1),
      .Width (DATA_W + 1)
    ) u_rsp (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (rsp_pop),
      .wdata_i ({rsp_err, rsp_data}),
      .pop_i   (~rsp_empty),
      .head_o  (rsp_head),
      .full_o  (rsp_full),
      .empty_o (rsp_empty),
      .count_o (rsp_count)
    );

    assign unused_rsp    = rsp_full ^ rsp_count[0];
    assign core_rvalid_o = ~rsp_empty;
    assign core_err_o    = rsp_empty ? 1'b0 : rsp_head[DATA_W];
    assign core_rdata_o  = rsp_empty ? '0 : rsp_head[DATA_W-1:0];
  end else begin : g_rsp_comb
    assign core_rvalid_o = rsp_pop;
    assign core_err_o    = rsp_err;
    assign core_rdata_o  = rsp_data;
  end

  // The core must hold req until a partially issued write has been granted.
  a_write_held: assert property (@(posedge clk) disable iff (!rst_n)
                                 (aw_done_q || w_done_q) |-> core_req_i)
    else $error("core_req_i dropped during a partially issued write");

endmodule

// File: tb/tb_core2axi4l_mo.sv
module tb_core2axi4l_mo;

  localparam int MO = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req_i = 1'b0, core_we_i = 1'b0;
  logic [3:0]  core_be_i = '0;
  logic [31:0] core_addr_i = '0, core_wdata_i = '0;
  logic        core_gnt_o, core_rvalid_o, core_err_o;
  logic [31:0] core_rdata_o;
  logic        axi_awvalid_o, axi_wvalid_o, axi_bready_o, axi_arvalid_o, axi_rready_o;
  logic        axi_awready_i = 1'b0, axi_wready_i = 1'b0, axi_arready_i = 1'b0;
  logic        axi_bvalid_i = 1'b0, axi_rvalid_i = 1'b0;
  logic [31:0] axi_awaddr_o, axi_araddr_o, axi_wdata_o;
  logic [31:0] axi_rdata_i = '0;
  logic [3:0]  axi_wstrb_o;
  logic [2:0]  axi_awprot_o, axi_arprot_o;
  logic [1:0]  axi_bresp_i = '0, axi_rresp_i = '0;

  always #5 clk = ~clk;

  core2axi4l_mo #(.MaxOutstanding(MO), .RspReg(1'b1), .Prot(3'b100)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_be_i(core_be_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
    .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
    .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
    .axi_awaddr_o(axi_awaddr_o), .axi_awprot_o(axi_awprot_o),
    .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
    .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o),
    .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o), .axi_bresp_i(axi_bresp_i),
    .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
    .axi_araddr_o(axi_araddr_o), .axi_arprot_o(axi_arprot_o),
    .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o),
    .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i)
  );

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Slave memory contents and response codes as a function of address.
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A0000);
  endfunction
  function automatic logic [1:0] resp_fn(input logic [31:0] a);
    case (a[15:12])
      4'hE:    return 2'b10;
      4'hD:    return 2'b11;
      4'hB:    return 2'b01;
      default: return 2'b00;
    endcase
  endfunction
  function automatic logic err_fn(input logic [31:0] a);
    return (resp_fn(a) == 2'b10) || (resp_fn(a) == 2'b11);
  endfunction

  typedef struct { logic [31:0] d; logic e; } exp_t;
  typedef struct { logic [31:0] a; int t; } sl_t;

  bit   ord_q[$];
  exp_t exp_q[$];
  exp_t rv_log[$];
  int   rv_cyc[$];
  sl_t  rq[$], bq[$];
  bit   aw_seen = 0, w_seen = 0, hs_prev = 0;
  int   cyc = 0, last_gnt_cyc = 0;
  int   lat_r = 1, lat_b = 1;
  bit   r_hold = 0, rand_mode = 0;

  // AXI slave: presents the oldest accepted request once its latency has elapsed.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (!rst_n) begin rq.delete(); bq.delete(); end
      if (rand_mode) axi_arready_i = 1'($urandom_range(0, 1));
      axi_rvalid_i = 1'b0; axi_rdata_i = '0; axi_rresp_i = '0;
      if (rst_n && rq.size() > 0 && rq[0].t <= cyc && !r_hold) begin
        axi_rvalid_i = 1'b1;
        axi_rdata_i  = rd_fn(rq[0].a);
        axi_rresp_i  = resp_fn(rq[0].a);
      end
      axi_bvalid_i = 1'b0; axi_bresp_i = '0;
      if (rst_n && bq.size() > 0 && bq[0].t <= cyc) begin
        axi_bvalid_i = 1'b1;
        axi_bresp_i  = resp_fn(bq[0].a);
      end
    end
  end

  bit   full_m, e_ar, e_aw, e_w, arh, awh, wh, e_gnt, e_rr, e_br, rh, bh;
  exp_t ex;

  // Reference model and per-cycle comparison.
  always @(negedge clk) begin
    if (!rst_n) begin
      ord_q.delete(); exp_q.delete(); rq.delete(); bq.delete();
      aw_seen = 0; w_seen = 0; hs_prev = 0;
    end else begin
      full_m = (ord_q.size() >= MO);
      e_ar   = core_req_i && !core_we_i && !full_m;
      e_aw   = core_req_i && core_we_i && !full_m && !aw_seen;
      e_w    = core_req_i && core_we_i && !full_m && !w_seen;
      arh    = e_ar && axi_arready_i;
      awh    = e_aw && axi_awready_i;
      wh     = e_w && axi_wready_i;
      e_gnt  = core_we_i ? (core_req_i && !full_m && (aw_seen || awh) && (w_seen || wh)) : arh;
      e_rr   = (ord_q.size() > 0) && (ord_q[0] == 1'b0);
      e_br   = (ord_q.size() > 0) && (ord_q[0] == 1'b1);
      rh     = e_rr && axi_rvalid_i;
      bh     = e_br && axi_bvalid_i;

      chk("arvalid", axi_arvalid_o, e_ar);
      chk("awvalid", axi_awvalid_o, e_aw);
      chk("wvalid",  axi_wvalid_o,  e_w);
      chk("gnt",     core_gnt_o,    e_gnt);
      chk("rready",  axi_rready_o,  e_rr);
      chk("bready",  axi_bready_o,  e_br);
      chk("rvalid",  core_rvalid_o, hs_prev);
      if (e_ar) begin
        chk("araddr", axi_araddr_o, core_addr_i);
        chk("arprot", axi_arprot_o, 32'h4);
      end
      if (e_aw) begin
        chk("awaddr", axi_awaddr_o, core_addr_i);
        chk("awprot", axi_awprot_o, 32'h4);
      end
      if (e_w) begin
        chk("wdata", axi_wdata_o, core_wdata_i);
        chk("wstrb", axi_wstrb_o, core_be_i);
      end
      if (core_rvalid_o) begin
        if (exp_q.size() == 0) chk("rvalid_unexpected", 1, 0);
        else begin
          ex = exp_q.pop_front();
          chk("rdata", core_rdata_o, ex.d);
          chk("err",   core_err_o,   ex.e);
        end
        rv_log.push_back('{d: core_rdata_o, e: core_err_o});
        rv_cyc.push_back(cyc);
      end

      if (e_gnt) begin
        ord_q.push_back(core_we_i);
        last_gnt_cyc = cyc;
        if (core_we_i) begin
          exp_q.push_back('{d: 32'h0, e: err_fn(core_addr_i)});
          bq.push_back('{a: core_addr_i, t: cyc + lat_b});
          aw_seen = 0; w_seen = 0;
        end else begin
          exp_q.push_back('{d: rd_fn(core_addr_i), e: err_fn(core_addr_i)});
          rq.push_back('{a: core_addr_i,
                         t: cyc + (rand_mode ? int'($urandom_range(0, 3)) : lat_r)});
        end
      end else begin
        if (awh) aw_seen = 1;
        if (wh)  w_seen = 1;
      end
      if (rh) begin void'(rq.pop_front()); void'(ord_q.pop_front()); end
      if (bh) begin void'(bq.pop_front()); void'(ord_q.pop_front()); end
      hs_prev = rh || bh;
    end
  end

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output int waits);
    bit g;
    core_req_i = 1'b1; core_we_i = we; core_addr_i = a; core_wdata_i = d; core_be_i = be;
    waits = 0;
    forever begin
      @(negedge clk);
      g = core_gnt_o;
      @(posedge clk); #1;
      if (g) break;
      waits++;
      if (waits > 200) begin
        chk("gnt_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic req_off();
    core_req_i = 1'b0; core_we_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(posedge clk); n++;
    end
    chk("drain_left", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic clr_log();
    rv_log.delete(); rv_cyc.delete();
  endtask

  initial begin
    int w;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    #3;
    chk("rst_gnt", core_gnt_o, 0);
    chk("rst_rvalid", core_rvalid_o, 0);
    chk("rst_err", core_err_o, 0);
    chk("rst_rdata", core_rdata_o, 0);
    chk("rst_rready", axi_rready_o, 0);
    chk("rst_bready", axi_bready_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    axi_arready_i = 1; axi_awready_i = 1; axi_wready_i = 1;
    @(posedge clk); #1;

    // Single read, slave answers 3 cycles after AR.
    clr_log(); lat_r = 3;
    issue(0, 32'h100, 0, 4'hF, w);
    chk("t1_gnt_wait", w, 0);
    req_off(); drain();
    chk("t1_count", rv_log.size(), 1);
    if (rv_log.size() == 1) begin
      chk("t1_rdata", rv_log[0].d, 32'hDEADBEEF);
      chk("t1_err", rv_log[0].e, 0);
      chk("t1_latency", rv_cyc[0] - last_gnt_cyc, 4);
    end
    lat_r = 1;

    // Write with AW accepted two cycles before W; slave error.
    clr_log();
    axi_wready_i = 0;
    core_req_i = 1; core_we_i = 1; core_addr_i = 32'hE200;
    core_wdata_i = 32'h12345678; core_be_i = 4'b0011;
    repeat (2) begin
      @(negedge clk); chk("t2_early_gnt", core_gnt_o, 0);
      @(posedge clk); #1;
    end
    axi_wready_i = 1;
    issue(1, 32'hE200, 32'h12345678, 4'b0011, w);
    chk("t2_gnt_wait", w, 0);
    req_off(); drain();
    chk("t2_count", rv_log.size(), 1);
    if (rv_log.size() == 1) begin
      chk("t2_rdata", rv_log[0].d, 0);
      chk("t2_err", rv_log[0].e, 1);
    end

    // Fill with R stalled; the extra request waits until one cycle after the first pop.
    clr_log(); r_hold = 1;
    for (int i = 0; i < MO; i++) begin
      issue(0, 32'h400 + 32'(4 * i), 0, 4'hF, w);
      chk("t3_fill_wait", w, 0);
    end
    core_req_i = 1; core_we_i = 0; core_addr_i = 32'h40C;
    repeat (4) begin
      @(negedge clk); chk("t3_full_gnt", core_gnt_o, 0);
      @(posedge clk); #1;
    end
    r_hold = 0;
    issue(0, 32'h40C, 0, 4'hF, w);
    chk("t3_unblock_wait", w, 1);
    req_off(); drain();
    chk("t3_count", rv_log.size(), 4);
    if (rv_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("t3_order", rv_log[i].d, 32'h5A5A0400 + 32'(4 * i));

    // Read A, write B, read C with B answered long before R(A).
    clr_log(); lat_r = 6; lat_b = 0;
    issue(0, 32'h200, 0, 4'hF, w);
    issue(1, 32'hE300, 32'h55, 4'hF, w);
    issue(0, 32'h304, 0, 4'hF, w);
    req_off(); drain();
    chk("t4_count", rv_log.size(), 3);
    if (rv_log.size() == 3) begin
      chk("t4_a", rv_log[0].d, 32'h5A5A0200);
      chk("t4_a_err", rv_log[0].e, 0);
      chk("t4_b", rv_log[1].d, 0);
      chk("t4_b_err", rv_log[1].e, 1);
      chk("t4_c", rv_log[2].d, 32'h5A5A0304);
    end
    lat_r = 1; lat_b = 1;

    // Streaming reads with random AR stalls and response delays.
    clr_log(); rand_mode = 1;
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a;
      a = (i == 5) ? 32'hD000 : (i == 9) ? 32'hB010 : 32'h1000 + 32'(4 * i);
      issue(0, a, 0, 4'hF, w);
    end
    req_off(); rand_mode = 0; axi_arready_i = 1;
    drain();
    chk("t5_count", rv_log.size(), 20);
    if (rv_log.size() == 20) begin
      chk("t5_first", rv_log[0].d, 32'h5A5A1000);
      chk("t5_last", rv_log[19].d, 32'h5A5A104C);
      chk("t5_decerr", rv_log[5].e, 1);
      chk("t5_exokay", rv_log[9].e, 0);
    end

    // Reset with two reads outstanding, then a fresh read.
    clr_log(); r_hold = 1;
    issue(0, 32'h500, 0, 4'hF, w);
    issue(0, 32'h504, 0, 4'hF, w);
    req_off();
    @(negedge clk); chk("t6_pre_rready", axi_rready_o, 1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("t6_rready", axi_rready_o, 0);
    chk("t6_bready", axi_bready_o, 0);
    chk("t6_gnt", core_gnt_o, 0);
    chk("t6_rvalid", core_rvalid_o, 0);
    chk("t6_rdata", core_rdata_o, 0);
    r_hold = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    clr_log();
    issue(0, 32'h600, 0, 4'hF, w);
    chk("t6_gnt_wait", w, 0);
    req_off(); drain();
    chk("t6_count", rv_log.size(), 1);
    if (rv_log.size() == 1) chk("t6_rdata_after", rv_log[0].d, 32'h5A5A0600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
